// File: rtl/softmax_pkg.sv
// Shared constants, FSM state encoding and row type for the softmax32 row driver.
package softmax_pkg;

    localparam int unsigned LANES = 32;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 12;
    localparam int unsigned RowW  = LANES * DW;
    localparam int unsigned IdxW  = $clog2(LANES);

    typedef enum logic [1:0] {
        StFill,
        StWrite,
        StCmpt,
        StOut
    } state_e;

    typedef logic [RowW-1:0] row_t;

endpackage

// File: rtl/row_packer.sv
// Packs accepted score bytes into a 256-bit row, lane 0 first, zero-padding short rows.
module row_packer
    import softmax_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    output row_t          row_o,
    output logic          done_o
);

    logic [IdxW-1:0] idx_q, idx_d;
    row_t            row_q, row_d;

    assign done_o = accept_i && (last_i || (idx_q == IdxW'(LANES - 1)));
    assign row_o  = row_q;

    always_comb begin
        idx_d = idx_q;
        row_d = row_q;
        if (accept_i) begin
            // Clearing on lane 0 leaves every lane beyond a short row at zero.
            if (idx_q == '0) begin
                row_d = '0;
            end
            for (int k = 0; k < LANES; k++) begin
                if (idx_q == IdxW'(k)) begin
                    row_d[k*DW +: DW] = data_i;
                end
            end
            idx_d = done_o ? '0 : idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            row_q <= '0;
        end else begin
            idx_q <= idx_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/softmax_row_driver.sv
// Host-side initiator for softmax32: fills a row, writes it, holds cme until a result or timeout.
// Optional SMDRV_LATENCY_EN adds lat_cycles, the wait count captured at each compute exit.
module softmax_row_driver
    import softmax_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          sm_en,
    output logic          sm_we,
    output logic          sm_cme,
    output logic [AW-1:0] sm_addr,
    output row_t          sm_cmIn,
    input  row_t          sm_cmOut,
    input  logic          sm_cmOutValid,
    output logic          m_valid,
    input  logic          m_ready,
    output row_t          m_data,
    output logic          m_err,
    output logic          busy
`ifdef SMDRV_LATENCY_EN
    ,
    output logic [7:0]    lat_cycles
`endif
);

    localparam int unsigned      WaitW    = 16;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [AW-1:0]    row_addr_q, row_addr_d;
    row_t             m_data_q, m_data_d;
    logic             m_err_q, m_err_d;
    row_t             row;
    logic             accept;
    logic             row_done;

    assign accept = s_valid && s_ready;

    row_packer u_row_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept_i (accept),
        .data_i   (s_data),
        .last_i   (s_last),
        .row_o    (row),
        .done_o   (row_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            wait_q     <= '0;
            row_addr_q <= '0;
            m_data_q   <= '0;
            m_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            row_addr_q <= row_addr_d;
            m_data_q   <= m_data_d;
            m_err_q    <= m_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        row_addr_d = row_addr_q;
        m_data_d   = m_data_q;
        m_err_d    = m_err_q;
        unique case (state_q)
            StFill: begin
                if (row_done) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                wait_d  = '0;
                state_d = StCmpt;
            end
            StCmpt: begin
                // A result arriving on the last allowed cycle wins over the timeout.
                if (sm_cmOutValid) begin
                    m_data_d = sm_cmOut;
                    m_err_d  = 1'b0;
                    state_d  = StOut;
                end else if (wait_q == WaitLast) begin
                    m_data_d = '0;
                    m_err_d  = 1'b1;
                    state_d  = StOut;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StOut: begin
                if (m_ready) begin
                    row_addr_d = row_addr_q + AW'(1);
                    state_d    = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        sm_en   = 1'b0;
        sm_we   = 1'b0;
        sm_cme  = 1'b0;
        sm_addr = '0;
        sm_cmIn = '0;
        m_valid = 1'b0;
        unique case (state_q)
            StFill:  s_ready = rst_n;
            StWrite: begin
                sm_en   = 1'b1;
                sm_we   = 1'b1;
                sm_addr = row_addr_q;
                sm_cmIn = row;
            end
            StCmpt: begin
                sm_en   = 1'b1;
                sm_cme  = 1'b1;
                sm_addr = row_addr_q;
            end
            StOut:   m_valid = 1'b1;
            default: s_ready = 1'b0;
        endcase
    end

    assign m_data = m_data_q;
    assign m_err  = m_err_q;
    assign busy   = (state_q != StFill);

`ifdef SMDRV_LATENCY_EN
    logic [7:0] lat_q, lat_d;

    always_comb begin
        lat_d = lat_q;
        if (state_q == StCmpt && (sm_cmOutValid || wait_q == WaitLast)) begin
            lat_d = (wait_q > WaitW'(255)) ? 8'hFF : wait_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

    assign lat_cycles = lat_q;
`endif

endmodule

// File: tb/tb_softmax_row_driver.sv
// Self-checking bench for softmax_row_driver with a behavioural softmax32 stub and row model.
module tb_softmax_row_driver;
    import softmax_pkg::*;

    localparam int unsigned TO = 64;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        bit            accepted;
        logic          we;
        logic [AW-1:0] addr;
        row_t          cmin;
        logic          we_after;
        int            cme_n;
        logic          m_valid;
        row_t          m_data;
        logic          m_err;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          sm_en, sm_we, sm_cme;
    logic [AW-1:0] sm_addr;
    row_t          sm_cmIn;
    row_t          sm_cmOut = '0;
    logic          sm_cmOutValid = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    row_t          m_data;
    logic          m_err;
    logic          busy;
`ifdef SMDRV_LATENCY_EN
    logic [7:0]    lat_cycles;
`endif

    int            n_checks = 0;
    int            n_pass = 0;
    logic [AW-1:0] exp_addr = '0;

    always #5 clk = ~clk;

    softmax_row_driver #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .sm_en         (sm_en),
        .sm_we         (sm_we),
        .sm_cme        (sm_cme),
        .sm_addr       (sm_addr),
        .sm_cmIn       (sm_cmIn),
        .sm_cmOut      (sm_cmOut),
        .sm_cmOutValid (sm_cmOutValid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_err         (m_err),
        .busy          (busy)
`ifdef SMDRV_LATENCY_EN
        ,
        .lat_cycles    (lat_cycles)
`endif
    );

    // Reference row: byte k lands in lane k, everything past the last byte is zero.
    function automatic row_t pack(input bq_t b);
        row_t r = '0;
        foreach (b[k]) r[k*8 +: 8] = b[k];
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic push_byte(input logic [7:0] d, input logic last, output bit ok);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok      = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Feeds one row, then plays softmax32: answers after delay+1 cme cycles (never if delay < 0).
    task automatic do_row(input bq_t b, input bit use_last, input int delay, input row_t resp,
                          output obs_t o);
        bit ok;
        o.accepted = 1'b1;
        foreach (b[k]) begin
            push_byte(b[k], use_last && (k == b.size() - 1), ok);
            if (!ok) o.accepted = 1'b0;
        end
        @(negedge clk);
        o.we       = sm_we;
        o.addr     = sm_addr;
        o.cmin     = sm_cmIn;
        o.cme_n    = 0;
        o.we_after = 1'bx;
        for (int n = 0; n < int'(TO) + 20; n++) begin
            @(negedge clk);
            sm_cmOutValid = 1'b0;
            sm_cmOut      = rand_row();
            if (n == 0) o.we_after = sm_we;
            if (sm_cme !== 1'b1) break;
            o.cme_n++;
            if (delay >= 0 && o.cme_n == delay + 1) begin
                sm_cmOutValid = 1'b1;
                sm_cmOut      = resp;
            end
        end
        o.m_valid = m_valid;
        o.m_data  = m_data;
        o.m_err   = m_err;
    endtask

    task automatic ack_out();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready  = 1'b0;
        exp_addr = exp_addr + AW'(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else n_pass++;
        n_checks++; if ({sm_en, sm_we, sm_cme, m_valid, m_err, busy} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {sm_en, sm_we, sm_cme, m_valid, m_err, busy}); else n_pass++;
        n_checks++; if (sm_addr !== '0) $display("FAIL reset_addr: got %0h want 0", sm_addr); else n_pass++;
        n_checks++; if (sm_cmIn !== '0) $display("FAIL reset_cmin: got %0h want 0", sm_cmIn); else n_pass++;
        n_checks++; if (m_data !== '0) $display("FAIL reset_m_data: got %0h want 0", m_data); else n_pass++;
`ifdef SMDRV_LATENCY_EN
        n_checks++; if (lat_cycles !== 8'd0) $display("FAIL reset_lat: got %0d want 0", lat_cycles); else n_pass++;
`endif
        rst_n    = 1'b1;
        exp_addr = '0;
        #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_release_s_ready: got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_full_row();
        byte unsigned in_v[32] = '{247, 112, 1, 233, 240, 149, 171, 21, 196, 60, 7, 201, 88, 159,
                                   157, 38, 46, 29, 3, 124, 247, 16, 138, 119, 153, 22, 148, 69,
                                   142, 165, 123, 90};
        byte unsigned out_v[32] = '{18, 6, 2, 16, 17, 8, 10, 3, 12, 4, 2, 13, 5, 9, 9, 3, 3, 3, 2,
                                    7, 18, 3, 8, 6, 9, 3, 8, 4, 8, 9, 7, 5};
        bq_t  b;
        row_t resp;
        obs_t o;
        int   delay;
        for (int i = 0; i < 32; i++) begin
            b.push_back(in_v[i]);
            resp[i*8 +: 8] = out_v[i];
        end
        delay   = $urandom_range(0, 5);
        m_ready = 1'b1;
        do_row(b, 1'b0, delay, resp, o);
        n_checks++; if (!o.accepted) $display("FAIL full_accept: got 0 want 1"); else n_pass++;
        n_checks++; if (o.we !== 1'b1) $display("FAIL full_we: got %b want 1", o.we); else n_pass++;
        n_checks++; if (o.addr !== 12'd0) $display("FAIL full_addr: got %0d want 0", o.addr); else n_pass++;
        n_checks++; if (o.cmin !== pack(b)) $display("FAIL full_cmin: got %0h want %0h", o.cmin, pack(b)); else n_pass++;
        n_checks++; if (o.we_after !== 1'b0) $display("FAIL full_we_one_cycle: got %b want 0", o.we_after); else n_pass++;
        n_checks++; if (o.cme_n != delay + 1) $display("FAIL full_cme_cycles: got %0d want %0d", o.cme_n, delay + 1); else n_pass++;
        n_checks++; if (o.m_valid !== 1'b1) $display("FAIL full_m_valid: got %b want 1", o.m_valid); else n_pass++;
        n_checks++; if (o.m_data !== resp) $display("FAIL full_m_data: got %0h want %0h", o.m_data, resp); else n_pass++;
        n_checks++; if (o.m_err !== 1'b0) $display("FAIL full_m_err: got %b want 0", o.m_err); else n_pass++;
        ack_out();
    endtask

    task automatic test_short_row();
        bq_t  b;
        row_t resp;
        obs_t o;
        b = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        for (int r = 0; r < 4; r++) begin
            if (r > 0) b = rand_bytes($urandom_range(1, 31));
            resp = rand_row();
            do_row(b, 1'b1, $urandom_range(0, 8), resp, o);
            n_checks++; if (o.we !== 1'b1) $display("FAIL short_we_r%0d: got %b want 1", r, o.we); else n_pass++;
            n_checks++; if (o.addr !== exp_addr) $display("FAIL short_addr_r%0d: got %0d want %0d", r, o.addr, exp_addr); else n_pass++;
            n_checks++; if (o.cmin !== pack(b)) $display("FAIL short_cmin_r%0d: got %0h want %0h", r, o.cmin, pack(b)); else n_pass++;
            n_checks++; if (o.m_data !== resp) $display("FAIL short_m_data_r%0d: got %0h want %0h", r, o.m_data, resp); else n_pass++;
            ack_out();
        end
    endtask

    task automatic test_timeout();
        bq_t  b;
        row_t resp;
        obs_t o;
        int   bad = 0;
        b = rand_bytes(32);
        resp = rand_row();
        do_row(b, 1'b0, -1, resp, o);
        n_checks++; if (o.cme_n != int'(TO)) $display("FAIL timeout_cme_cycles: got %0d want %0d", o.cme_n, TO); else n_pass++;
        n_checks++; if (o.m_valid !== 1'b1) $display("FAIL timeout_m_valid: got %b want 1", o.m_valid); else n_pass++;
        n_checks++; if (o.m_err !== 1'b1) $display("FAIL timeout_m_err: got %b want 1", o.m_err); else n_pass++;
        n_checks++; if (o.m_data !== '0) $display("FAIL timeout_m_data: got %0h want 0", o.m_data); else n_pass++;
        // Late cmOutValid while waiting in OUT must be ignored.
        for (int i = 0; i < 6; i++) begin
            sm_cmOutValid = 1'b1;
            sm_cmOut      = rand_row();
            @(negedge clk);
            if (busy !== 1'b1 || m_valid !== 1'b1 || m_err !== 1'b1 || m_data !== '0) bad++;
        end
        sm_cmOutValid = 1'b0;
        n_checks++; if (bad != 0) $display("FAIL timeout_hold: got %0d bad cycles want 0", bad); else n_pass++;
        ack_out();
        n_checks++; if (busy !== 1'b0) $display("FAIL timeout_busy_after_ack: got %b want 0", busy); else n_pass++;
        b = rand_bytes(4);
        resp = rand_row();
        do_row(b, 1'b1, int'(TO) - 1, resp, o);
        n_checks++; if (o.m_err !== 1'b0) $display("FAIL tie_m_err: got %b want 0", o.m_err); else n_pass++;
        n_checks++; if (o.m_data !== resp) $display("FAIL tie_m_data: got %0h want %0h", o.m_data, resp); else n_pass++;
        ack_out();
    endtask

    task automatic test_backpressure();
        bq_t  b, nb;
        row_t resp;
        obs_t o;
        b  = rand_bytes(32);
        nb = rand_bytes(7);
        resp = rand_row();
        do_row(b, 1'b0, $urandom_range(0, 10), resp, o);
        s_valid = 1'b1;
        s_data  = nb[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== resp || s_ready !== 1'b0)
                $display("FAIL hold_c%0d: got v=%b s_ready=%b data=%0h want v=1 s_ready=0 data=%0h",
                         i, m_valid, s_ready, m_data, resp);
            else n_pass++;
        end
        ack_out();
        resp = rand_row();
        do_row(nb, 1'b1, 2, resp, o);
        n_checks++; if (o.cmin !== pack(nb)) $display("FAIL bp_next_cmin: got %0h want %0h", o.cmin, pack(nb)); else n_pass++;
        n_checks++; if (o.addr !== exp_addr) $display("FAIL bp_next_addr: got %0d want %0d", o.addr, exp_addr); else n_pass++;
        ack_out();
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 8; r++) begin
            int   len      = $urandom_range(1, 32);
            bit   use_last = (len < 32) || ($urandom_range(0, 1) == 1);
            int   delay    = (r == 0) ? 70 : int'($urandom_range(0, 70));
            bit   exp_err  = (delay > int'(TO) - 1);
            bq_t  b        = rand_bytes(len);
            row_t resp     = rand_row();
            obs_t o;
            m_ready = 1'($urandom_range(0, 1));
            do_row(b, use_last, delay, resp, o);
            n_checks++; if (o.addr !== exp_addr) $display("FAIL rnd_addr_r%0d: got %0d want %0d", r, o.addr, exp_addr); else n_pass++;
            n_checks++; if (o.cmin !== pack(b)) $display("FAIL rnd_cmin_r%0d: got %0h want %0h", r, o.cmin, pack(b)); else n_pass++;
            n_checks++; if (o.cme_n != (exp_err ? int'(TO) : delay + 1))
                $display("FAIL rnd_cme_r%0d: got %0d want %0d", r, o.cme_n, exp_err ? int'(TO) : delay + 1); else n_pass++;
            n_checks++; if (o.m_err !== exp_err) $display("FAIL rnd_err_r%0d: got %b want %b", r, o.m_err, exp_err); else n_pass++;
            n_checks++; if (o.m_data !== (exp_err ? '0 : resp))
                $display("FAIL rnd_data_r%0d: got %0h want %0h", r, o.m_data, exp_err ? '0 : resp); else n_pass++;
            ack_out();
        end
    endtask

    task automatic test_wrap();
        obs_t          o;
        int            bad = 0;
        logic [AW-1:0] addr_4096 = '0;
        logic [AW-1:0] addr_4097 = '1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_addr = '0;
        m_ready  = 1'b1;
        for (int r = 0; r < 4097; r++) begin
            bq_t b = rand_bytes(1);
            do_row(b, 1'b1, 0, rand_row(), o);
            if (!o.accepted) begin
                bad++;
                break;
            end
            if (o.addr !== exp_addr) bad++;
            if (r == 4095) addr_4096 = o.addr;
            if (r == 4096) addr_4097 = o.addr;
            @(negedge clk);
            exp_addr = exp_addr + AW'(1);
        end
        m_ready = 1'b0;
        n_checks++; if (bad != 0) $display("FAIL wrap_addr_seq: got %0d bad rows want 0", bad); else n_pass++;
        n_checks++; if (addr_4096 !== 12'd4095) $display("FAIL wrap_row4096: got %0d want 4095", addr_4096); else n_pass++;
        n_checks++; if (addr_4097 !== 12'd0) $display("FAIL wrap_row4097: got %0d want 0", addr_4097); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bq_t  b;
        row_t resp;
        obs_t o;
        bit   ok;
        b = rand_bytes(3);
        foreach (b[k]) push_byte(b[k], k == 2, ok);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sm_cme !== 1'b1) $display("FAIL rmid_in_cmpt: got %b want 1", sm_cme); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({sm_cme, sm_en, m_valid, busy} !== 4'b0)
            $display("FAIL rmid_drop: got %b want 0000", {sm_cme, sm_en, m_valid, busy}); else n_pass++;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_addr = '0;
        #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready: got %b want 1", s_ready); else n_pass++;
        b = rand_bytes(6);
        resp = rand_row();
        do_row(b, 1'b1, 3, resp, o);
        n_checks++; if (o.addr !== 12'd0) $display("FAIL rmid_next_addr: got %0d want 0", o.addr); else n_pass++;
        n_checks++; if (o.cmin !== pack(b)) $display("FAIL rmid_next_cmin: got %0h want %0h", o.cmin, pack(b)); else n_pass++;
        n_checks++; if (o.m_data !== resp) $display("FAIL rmid_next_data: got %0h want %0h", o.m_data, resp); else n_pass++;
        ack_out();
    endtask

`ifdef SMDRV_LATENCY_EN
    task automatic test_latency();
        obs_t o;
        int   d;
        do_row(rand_bytes(8), 1'b1, 9, rand_row(), o);
        ack_out();
        n_checks++; if (lat_cycles !== 8'd9) $display("FAIL lat_10th: got %0d want 9", lat_cycles); else n_pass++;
        d = $urandom_range(0, 40);
        do_row(rand_bytes(32), 1'b0, d, rand_row(), o);
        repeat (3) @(negedge clk);
        n_checks++; if (lat_cycles !== 8'(d)) $display("FAIL lat_rand: got %0d want %0d", lat_cycles, d); else n_pass++;
        ack_out();
        do_row(rand_bytes(2), 1'b1, -1, rand_row(), o);
        ack_out();
        n_checks++; if (lat_cycles !== 8'(TO - 1)) $display("FAIL lat_timeout: got %0d want %0d", lat_cycles, TO - 1); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_row();
        test_short_row();
        test_timeout();
        test_backpressure();
        test_random_rows();
        test_wrap();
        test_reset_mid();
`ifdef SMDRV_LATENCY_EN
        test_latency();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/softmax_row_driver.md
Name: softmax_row_driver

Overview:
- Initiator for the softmax32 command/memory port: the host-facing end of that interface.
- Accepts attention scores as an 8-bit byte stream and packs 32 of them into one 256-bit row.
- Writes the row into softmax32 (en/we/addr/cmIn), then holds the compute enable (cme) until cmOutValid.
- Captures cmOut and presents the normalized row to the downstream consumer on a valid/ready handshake.

Parameters:
- LANES, 32, scores per row.
- DW, 8, bits per score.
- AW, 12, softmax32 address width.
- TIMEOUT, 64, max cycles cme is held waiting for cmOutValid.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  score byte valid.
- s_ready  out  1  score byte accepted when s_valid && s_ready.
- s_data  in  DW  score byte.
- s_last  in  1  last byte of a short row.
- sm_en  out  1  softmax32 en.
- sm_we  out  1  softmax32 we.
- sm_cme  out  1  softmax32 cme.
- sm_addr  out  AW  softmax32 addr.
- sm_cmIn  out  LANES*DW  softmax32 cmIn.
- sm_cmOut  in  LANES*DW  softmax32 cmOut.
- sm_cmOutValid  in  1  softmax32 cmOutValid.
- m_valid  out  1  result row valid.
- m_ready  in  1  result row accepted.
- m_data  out  LANES*DW  result row.
- m_err  out  1  timeout flag, qualified by m_valid.
- busy  out  1  high in any state other than FILL.

Behaviour:
- Reset values:
  - All outputs 0, except s_ready, which is 1 when rst_n is high and the state is FILL.
  - State = FILL, lane index = 0, row register = 0, row_addr = 0.
- Lane mapping: byte k of a row goes to bits [k*8+7:k*8]; lane 0 is the first byte accepted.
- FILL:
  - s_ready = 1; each accepted byte is written to the lane at the lane index, which then increments.
  - Leave for WRITE on the 32nd accepted byte, or on any accepted byte with s_last = 1.
  - A short row pads the remaining lanes with 8'd0.
  - s_last on the 32nd byte behaves as a full row.
- WRITE (exactly 1 cycle):
  - sm_en = 1, sm_we = 1, sm_addr = row_addr, sm_cmIn = row register.
  - Next state: CMPT.
- CMPT:
  - sm_en = 1, sm_cme = 1, sm_we = 0, sm_addr = row_addr.
  - A wait counter starts at 0 on entry and increments every cycle.
  - When sm_cmOutValid is sampled high: register sm_cmOut into m_data, set m_err = 0, go to OUT.
  - If the counter reaches TIMEOUT-1 without cmOutValid: m_data = 0, m_err = 1, go to OUT.
  - cmOutValid and the timeout in the same cycle resolve as valid.
  - sm_cmOutValid outside CMPT is ignored.
- OUT:
  - m_valid = 1; m_data and m_err are held stable until m_valid && m_ready.
  - On handshake: row_addr increments (wraps 4095 -> 0), lane index clears, next state FILL.
  - s_ready = 0 throughout OUT.
- Latency: last byte accepted at cycle N -> sm_we at N+1 -> sm_cme from N+2 -> m_valid in the cycle after cmOutValid is sampled.
- Throughput: one row in flight; no overlap of fill with compute.
- Reset mid-operation: an asynchronous drop of rst_n clears the state immediately. sm_* deassert with no partial write/compute continuation, and the in-progress row is discarded.
- s_valid while s_ready = 0 is held off; no byte is lost.

Optional Feature:
- Macro SMDRV_LATENCY_EN.
- Defined:
  - Adds output port lat_cycles[7:0]: the wait-counter value at CMPT exit, registered on that exit, saturating at 255.
  - Reset value 0.
  - Holds until the next CMPT exit, including exits by timeout.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package softmax_pkg:
  - Constants LANES, DW, AW.
  - State enum {FILL, WRITE, CMPT, OUT}.
  - Row type logic [LANES*DW-1:0].
- One sub-module, row_packer: byte-to-row shift/index logic with zero padding and s_last handling. The FSM and softmax32 port timing stay in the top module.

Test Plan:
- Full row through a real softmax32, m_ready = 1.
  - Stimulus: 32 bytes 247,112,1,233,240,149,171,21,196,60,7,201,88,159,157,38,46,29,3,124,247,16,138,119,153,22,148,69,142,165,123,90.
  - Required response: sm_we for 1 cycle with addr = 0; m_valid with lanes 18,6,2,16,17,8,10,3,12,4,2,13,5,9,9,3,3,3,2,7,18,3,8,6,9,3,8,4,8,9,7,5; m_err = 0.
- Short row.
  - Stimulus: 5 bytes 10,20,30,40,50 with s_last on the 5th.
  - Required response: sm_cmIn lanes 0-4 = 10..50, lanes 5-31 = 0; sm_we in the cycle after the 5th byte.
- Timeout.
  - Stimulus: stub that never asserts cmOutValid.
  - Required response: cme high exactly 64 cycles, then m_valid = 1, m_err = 1, m_data = 0; busy until m_ready.
- Backpressure and address wrap.
  - Stimulus: hold m_ready = 0 for 20 cycles; issue 4097 rows.
  - Required response: m_data stable and s_ready = 0 throughout the hold; row 4097 is written at addr 0.
- Reset mid-compute.
  - Stimulus: drop rst_n during CMPT.
  - Required response: sm_cme = 0 and m_valid = 0 the same cycle; after release, s_ready = 1 and the next row is written at addr 0.
- Latency counter (SMDRV_LATENCY_EN defined).
  - Stimulus: stub asserts cmOutValid on the 10th CMPT cycle.
  - Required response: lat_cycles = 9 after the row completes.
